// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings (common with the receiver), data width
// and the clock-to-baud tick calculation.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd5
   } uart_state_t;

   localparam int NUM_DATA_BITS = 8;
   localparam int TICK_WIDTH    = 16;

   function automatic int ticks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between host-side logic (master) and the UART transmitter (slave).
interface uart_tx_if;
   import uart_pkg::*;

   logic                     valid;
   logic [NUM_DATA_BITS-1:0] data;
   logic                     ready;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..TICKS_PER_BIT-1 while enabled, pulses bit_end on the
// last tick of each bit. Shared with the UART receiver.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int TICKS_PER_BIT = 8
)(
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic bit_end
);

   localparam logic [TICK_WIDTH-1:0] LAST_TICK = TICK_WIDTH'(TICKS_PER_BIT - 1);

   logic [TICK_WIDTH-1:0] tick_count_reg;

   assign bit_end = enable && !clear && (tick_count_reg == LAST_TICK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_count_reg <= '0;
      end else if (clear || bit_end) begin
         tick_count_reg <= '0;
      end else if (enable) begin
         tick_count_reg <= tick_count_reg + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1/8N2 by default; defining UART_TX_PARITY_EN inserts an
// even/odd parity bit (PARITY_ODD) between data bit 7 and the stop bit(s).
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQUENCY  = 66_000_000,
   parameter int UART_FREQUENCY = 921_600,
   parameter int STOP_BITS      = 1
`ifdef UART_TX_PARITY_EN
   ,
   parameter int PARITY_ODD     = 0
`endif
)(
   input  logic     clk,
   input  logic     rst_n,
   uart_tx_if.slave bus,
   output logic     busy,
   output logic     tx
);

   localparam int             TICKS_PER_BIT = ticks_per_bit(CLK_FREQUENCY, UART_FREQUENCY);
   localparam logic [2:0]     LAST_DATA_BIT = 3'(NUM_DATA_BITS - 1);
   localparam logic [2:0]     LAST_STOP_BIT = 3'(STOP_BITS - 1);

   generate
      if (TICKS_PER_BIT < 2 || TICKS_PER_BIT > 65535) begin : g_bad_ticks
         $error("uart_tx: TICKS_PER_BIT=%0d outside 2..65535", TICKS_PER_BIT);
      end
      if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
         $error("uart_tx: STOP_BITS=%0d must be 1 or 2", STOP_BITS);
      end
   endgenerate

   uart_state_t              state_reg;
   logic [NUM_DATA_BITS-1:0] sh_reg;
   logic [2:0]               bit_count_reg;
   logic                     ready_reg;
   logic                     busy_reg;
   logic                     tx_reg;
   logic                     bit_end;
   logic                     tick_clear;
`ifdef UART_TX_PARITY_EN
   logic                     parity_reg;
`endif

   assign tick_clear = (state_reg == ST_IDLE);
   assign bus.ready  = ready_reg;
   assign busy       = busy_reg;
   assign tx         = tx_reg;

   uart_baud_tick #(
      .TICKS_PER_BIT (TICKS_PER_BIT)
   ) u_baud_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (tick_clear),
      .enable  (1'b1),
      .bit_end (bit_end)
   );

   // tx is loaded one bit ahead so it changes on the same edge as the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         sh_reg        <= '0;
         bit_count_reg <= '0;
         ready_reg     <= 1'b0;
         busy_reg      <= 1'b0;
         tx_reg        <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_reg    <= 1'b0;
`endif
      end else begin
         case (state_reg)
            ST_IDLE: begin
               ready_reg <= 1'b1;
               if (bus.valid && ready_reg) begin
                  state_reg  <= ST_START;
                  sh_reg     <= bus.data;
                  tx_reg     <= 1'b0;
                  ready_reg  <= 1'b0;
                  busy_reg   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                  parity_reg <= (^bus.data) ^ PARITY_ODD[0];
`endif
               end
            end
            ST_START: begin
               if (bit_end) begin
                  state_reg     <= ST_DATA;
                  bit_count_reg <= '0;
                  tx_reg        <= sh_reg[0];
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  sh_reg        <= {1'b0, sh_reg[NUM_DATA_BITS-1:1]};
                  bit_count_reg <= bit_count_reg + 3'd1;
                  if (bit_count_reg == LAST_DATA_BIT) begin
                     bit_count_reg <= '0;
`ifdef UART_TX_PARITY_EN
                     state_reg     <= ST_PARITY;
                     tx_reg        <= parity_reg;
`else
                     state_reg     <= ST_STOP;
                     tx_reg        <= 1'b1;
`endif
                  end else begin
                     tx_reg <= sh_reg[1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (bit_end) begin
                  state_reg     <= ST_STOP;
                  bit_count_reg <= '0;
                  tx_reg        <= 1'b1;
               end
            end
`endif
            ST_STOP: begin
               if (bit_end) begin
                  if (bit_count_reg == LAST_STOP_BIT) begin
                     state_reg <= ST_IDLE;
                     ready_reg <= 1'b1;
                     busy_reg  <= 1'b0;
                  end else begin
                     bit_count_reg <= bit_count_reg + 3'd1;
                  end
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               ready_reg <= 1'b0;
               busy_reg  <= 1'b0;
               tx_reg    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 8 clocks per bit: 8N1, 8N2 and (with
// UART_TX_PARITY_EN) even/odd parity instances.
module tb_uart_tx;

   localparam int T = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   uart_tx_if bus0 ();
   uart_tx_if bus1 ();
   logic busy0, tx0, busy1, tx1;

   uart_tx #(.CLK_FREQUENCY(8_000_000), .UART_FREQUENCY(1_000_000), .STOP_BITS(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0), .busy(busy0), .tx(tx0));
   uart_tx #(.CLK_FREQUENCY(8_000_000), .UART_FREQUENCY(1_000_000), .STOP_BITS(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1), .tx(tx1));

`ifdef UART_TX_PARITY_EN
   uart_tx_if bus2 ();
   uart_tx_if bus3 ();
   logic busy2, tx2, busy3, tx3;

   uart_tx #(.CLK_FREQUENCY(8_000_000), .UART_FREQUENCY(1_000_000), .STOP_BITS(1),
             .PARITY_ODD(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2), .busy(busy2), .tx(tx2));
   uart_tx #(.CLK_FREQUENCY(8_000_000), .UART_FREQUENCY(1_000_000), .STOP_BITS(1),
             .PARITY_ODD(1)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3), .busy(busy3), .tx(tx3));
`endif

   logic cap_tx   [0:255];
   logic cap_rdy  [0:255];
   logic cap_busy [0:255];

   function automatic logic get_tx(input int w);
      case (w)
         0: return tx0;
         1: return tx1;
`ifdef UART_TX_PARITY_EN
         2: return tx2;
         3: return tx3;
`endif
         default: return 1'bx;
      endcase
   endfunction

   function automatic logic get_ready(input int w);
      case (w)
         0: return bus0.ready;
         1: return bus1.ready;
`ifdef UART_TX_PARITY_EN
         2: return bus2.ready;
         3: return bus3.ready;
`endif
         default: return 1'bx;
      endcase
   endfunction

   function automatic logic get_busy(input int w);
      case (w)
         0: return busy0;
         1: return busy1;
`ifdef UART_TX_PARITY_EN
         2: return busy2;
         3: return busy3;
`endif
         default: return 1'bx;
      endcase
   endfunction

   task automatic drive(input int w, input logic v, input logic [7:0] d);
      case (w)
         0: begin bus0.valid = v; bus0.data = d; end
         1: begin bus1.valid = v; bus1.data = d; end
`ifdef UART_TX_PARITY_EN
         2: begin bus2.valid = v; bus2.data = d; end
         3: begin bus3.valid = v; bus3.data = d; end
`endif
         default: ;
      endcase
   endtask

   // Expected line level j cycles after the accept edge (start, 8 data bits, optional parity, then high).
   function automatic logic exp_bit(input logic [7:0] b, input int j, input int par_en, input logic par);
      if (j < T) return 1'b0;
      if (j < 9*T) return b[(j - T) / T];
      if (par_en != 0 && j < 10*T) return par;
      return 1'b1;
   endfunction

   // Returns at the negedge right after the accept edge, with valid already dropped.
   task automatic send(input int w, input logic [7:0] b);
      int waited = 0;
      @(negedge clk);
      drive(w, 1'b1, b);
      while (get_ready(w) !== 1'b1 && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      n_assert++;
      if (get_ready(w) !== 1'b1) begin
         n_fail++;
         $display("FAIL send_timeout dut%0d: ready=%b required 1", w, get_ready(w));
         drive(w, 1'b0, 8'h00);
      end else begin
         @(posedge clk);
         @(negedge clk);
         drive(w, 1'b0, 8'h00);
      end
   endtask

   task automatic capture(input int w, input int n);
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clk);
         cap_tx[i]   = get_tx(w);
         cap_rdy[i]  = get_ready(w);
         cap_busy[i] = get_busy(w);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_assert++; if (tx0 !== 1'b1)        begin n_fail++; $display("FAIL reset_tx: tx=%b required 1", tx0); end
      n_assert++; if (bus0.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: ready=%b required 0", bus0.ready); end
      n_assert++; if (busy0 !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: busy=%b required 0", busy0); end
      n_assert++; if (tx1 !== 1'b1)        begin n_fail++; $display("FAIL reset_tx_s2: tx=%b required 1", tx1); end
      rst_n = 1'b1;
      #1;
      n_assert++; if (bus0.ready !== 1'b0) begin n_fail++; $display("FAIL release_ready_early: ready=%b required 0", bus0.ready); end
      @(negedge clk);
      n_assert++; if (bus0.ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: ready=%b required 1", bus0.ready); end
      n_assert++; if (tx0 !== 1'b1)        begin n_fail++; $display("FAIL release_tx: tx=%b required 1", tx0); end
      $display("reset: done, failures so far %0d", n_fail);
   endtask

   task automatic test_frame_a5();
      logic [7:0] b;
      b = 8'hA5;
      send(0, b);
      capture(0, 81);
      for (int j = 0; j < 81; j++) begin
         n_assert++;
         if (cap_tx[j] !== exp_bit(b, j, 0, 1'b0)) begin
            n_fail++;
            $display("FAIL a5_tx j=%0d: tx=%b required %b", j, cap_tx[j], exp_bit(b, j, 0, 1'b0));
         end
      end
      n_assert++; if (cap_busy[0] !== 1'b1)  begin n_fail++; $display("FAIL a5_busy_start: busy=%b required 1", cap_busy[0]); end
      n_assert++; if (cap_rdy[0] !== 1'b0)   begin n_fail++; $display("FAIL a5_ready_drop: ready=%b required 0", cap_rdy[0]); end
      n_assert++; if (cap_rdy[79] !== 1'b0)  begin n_fail++; $display("FAIL a5_ready_79: ready=%b required 0", cap_rdy[79]); end
      n_assert++; if (cap_rdy[80] !== 1'b1)  begin n_fail++; $display("FAIL a5_ready_80: ready=%b required 1", cap_rdy[80]); end
      n_assert++; if (cap_busy[79] !== 1'b1) begin n_fail++; $display("FAIL a5_busy_79: busy=%b required 1", cap_busy[79]); end
      n_assert++; if (cap_busy[80] !== 1'b0) begin n_fail++; $display("FAIL a5_busy_80: busy=%b required 0", cap_busy[80]); end
      $display("frame 0xA5: done, failures so far %0d", n_fail);
   endtask

   task automatic test_back_to_back();
      int acc [2];
      int nacc = 0;
      int i = 0;
      @(negedge clk);
      drive(0, 1'b1, 8'h00);
      while (nacc < 2 && i < 200) begin
         if (i > 0) @(negedge clk);
         cap_tx[i] = tx0;
         if (bus0.ready === 1'b1) begin
            acc[nacc] = i;
            nacc++;
         end else if (nacc == 1) begin
            drive(0, 1'b1, 8'hFF);
         end
         i++;
      end
      n_assert++;
      if (nacc != 2) begin
         n_fail++;
         $display("FAIL b2b_accepts: accepts=%0d required 2", nacc);
         drive(0, 1'b0, 8'h00);
         return;
      end
      for (int k = 0; k < 81; k++) begin
         @(negedge clk);
         if (k == 0) drive(0, 1'b0, 8'h00);
         cap_tx[i] = tx0;
         i++;
      end
      n_assert++;
      if (acc[1] - acc[0] != 81) begin
         n_fail++;
         $display("FAIL b2b_period: period=%0d required 81", acc[1] - acc[0]);
      end
      for (int s = acc[0] + 1; s < i; s++) begin
         logic e;
         if (s <= acc[1]) e = exp_bit(8'h00, s - acc[0] - 1, 0, 1'b0);
         else             e = exp_bit(8'hFF, s - acc[1] - 1, 0, 1'b0);
         n_assert++;
         if (cap_tx[s] !== e) begin
            n_fail++;
            $display("FAIL b2b_tx s=%0d: tx=%b required %b", s, cap_tx[s], e);
         end
      end
      $display("back-to-back 0x00/0xFF: done, failures so far %0d", n_fail);
   endtask

   task automatic test_ignore_busy();
      logic [7:0] b;
      b = 8'h96;
      send(0, b);
      for (int j = 0; j < 121; j++) begin
         if (j > 0) @(negedge clk);
         if (j == 20)      drive(0, 1'b1, 8'h3C);
         else if (j == 21) drive(0, 1'b0, 8'h00);
         cap_tx[j]   = tx0;
         cap_busy[j] = busy0;
      end
      for (int j = 0; j < 121; j++) begin
         n_assert++;
         if (cap_tx[j] !== exp_bit(b, j, 0, 1'b0)) begin
            n_fail++;
            $display("FAIL ignore_tx j=%0d: tx=%b required %b", j, cap_tx[j], exp_bit(b, j, 0, 1'b0));
         end
         n_assert++;
         if (cap_busy[j] !== (j < 80)) begin
            n_fail++;
            $display("FAIL ignore_busy j=%0d: busy=%b required %b", j, cap_busy[j], (j < 80));
         end
      end
      $display("ignore while busy: done, failures so far %0d", n_fail);
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      send(0, 8'h00);
      capture(0, 30);
      n_assert++; if (cap_tx[29] !== 1'b0) begin n_fail++; $display("FAIL mid_pre_tx: tx=%b required 0", cap_tx[29]); end
      #2 rst_n = 1'b0;
      #1;
      n_assert++; if (tx0 !== 1'b1)        begin n_fail++; $display("FAIL mid_rst_tx: tx=%b required 1", tx0); end
      n_assert++; if (bus0.ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: ready=%b required 0", bus0.ready); end
      n_assert++; if (busy0 !== 1'b0)      begin n_fail++; $display("FAIL mid_rst_busy: busy=%b required 0", busy0); end
      repeat (2) @(negedge clk);
      n_assert++; if (tx0 !== 1'b1)        begin n_fail++; $display("FAIL mid_hold_tx: tx=%b required 1", tx0); end
      rst_n = 1'b1;
      @(negedge clk);
      n_assert++; if (bus0.ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready: ready=%b required 1", bus0.ready); end
      b = 8'h81;
      send(0, b);
      capture(0, 81);
      for (int j = 0; j < 81; j++) begin
         n_assert++;
         if (cap_tx[j] !== exp_bit(b, j, 0, 1'b0)) begin
            n_fail++;
            $display("FAIL mid_81_tx j=%0d: tx=%b required %b", j, cap_tx[j], exp_bit(b, j, 0, 1'b0));
         end
      end
      n_assert++; if (cap_rdy[80] !== 1'b1) begin n_fail++; $display("FAIL mid_81_ready: ready=%b required 1", cap_rdy[80]); end
      $display("reset mid-frame then 0x81: done, failures so far %0d", n_fail);
   endtask

   task automatic test_stop2();
      logic [7:0] b;
      b = 8'h55;
      send(1, b);
      capture(1, 89);
      for (int j = 0; j < 89; j++) begin
         n_assert++;
         if (cap_tx[j] !== exp_bit(b, j, 0, 1'b0)) begin
            n_fail++;
            $display("FAIL stop2_tx j=%0d: tx=%b required %b", j, cap_tx[j], exp_bit(b, j, 0, 1'b0));
         end
      end
      n_assert++; if (cap_rdy[80] !== 1'b0)  begin n_fail++; $display("FAIL stop2_ready_80: ready=%b required 0", cap_rdy[80]); end
      n_assert++; if (cap_rdy[87] !== 1'b0)  begin n_fail++; $display("FAIL stop2_ready_87: ready=%b required 0", cap_rdy[87]); end
      n_assert++; if (cap_rdy[88] !== 1'b1)  begin n_fail++; $display("FAIL stop2_ready_88: ready=%b required 1", cap_rdy[88]); end
      n_assert++; if (cap_busy[87] !== 1'b1) begin n_fail++; $display("FAIL stop2_busy_87: busy=%b required 1", cap_busy[87]); end
      $display("two stop bits 0x55: done, failures so far %0d", n_fail);
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      logic [7:0] b;
      logic       par_exp [2];
      b = 8'h07;
      par_exp[0] = 1'b1;   // even parity over three ones
      par_exp[1] = 1'b0;   // odd parity over three ones
      for (int k = 0; k < 2; k++) begin
         send(2 + k, b);
         capture(2 + k, 89);
         for (int j = 0; j < 89; j++) begin
            n_assert++;
            if (cap_tx[j] !== exp_bit(b, j, 1, par_exp[k])) begin
               n_fail++;
               $display("FAIL parity%0d_tx j=%0d: tx=%b required %b", k, j, cap_tx[j], exp_bit(b, j, 1, par_exp[k]));
            end
         end
         n_assert++; if (cap_rdy[87] !== 1'b0) begin n_fail++; $display("FAIL parity%0d_ready_87: ready=%b required 0", k, cap_rdy[87]); end
         n_assert++; if (cap_rdy[88] !== 1'b1) begin n_fail++; $display("FAIL parity%0d_ready_88: ready=%b required 1", k, cap_rdy[88]); end
         $display("parity odd=%0d 0x07: done, failures so far %0d", k, n_fail);
      end
   endtask
`endif

   initial begin
      drive(0, 1'b0, 8'h00);
      drive(1, 1'b0, 8'h00);
`ifdef UART_TX_PARITY_EN
      drive(2, 1'b0, 8'h00);
      drive(3, 1'b0, 8'h00);
`endif
      test_reset();
      test_frame_a5();
      test_back_to_back();
      test_ignore_busy();
      test_reset_mid();
      test_stop2();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: accepts one byte over a valid/ready parallel handshake and serialises it on `tx`.
- Frame format: 8N1 by default, or 8E1/8O1 with the optional parity feature.
- Bit timing derives from the FPGA clock and the UART frequency, matching the team's UART receiver's parameterisation.
- Sits between host-side logic (FIFO/controller) and the FPGA UART TX pin.

Parameters:
- CLK_FREQUENCY, 66_000_000, FPGA clock frequency in Hz.
- UART_FREQUENCY, 921_600, baud rate in Hz.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- Derived localparam TICKS_PER_BIT = CLK_FREQUENCY / UART_FREQUENCY (integer division).
- TICKS_PER_BIT must satisfy 2 ≤ TICKS_PER_BIT ≤ 65535. Elaboration-time check: $error if violated.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- valid  input  1  `data` holds a byte to send
- data  input  8  byte to transmit, LSB first
- ready  output  1  transmitter can accept a byte this cycle
- busy  output  1  frame in progress (any state other than IDLE)
- tx  output  1  serial line; idles high

Behaviour:
- Reset: clk and reset rst_n (asynchronous, active-low). While rst_n=0:
  - tx=1, ready=0, busy=0.
  - State=IDLE; tick and bit counters cleared.
- First rising clk after reset release: ready=1.
- Reset asserted mid-frame: frame aborted immediately; tx forced to 1, no glitch low.
- All outputs are registered. No combinational path from valid/data to any output.
- Handshake:
  - Transfer occurs on a rising edge with valid=1 and ready=1.
  - `data` is captured into shift register sh[7:0] on that edge.
  - ready is 1 only in IDLE. ready drops the cycle after acceptance.
  - valid while ready=0 is ignored; no queuing.
  - The sender must hold data stable only on the transfer edge.
- States: IDLE, START, DATA, PARITY (feature only), STOP.
  - IDLE → START on transfer. tx=0 from the next cycle.
  - START: tx=0 for exactly TICKS_PER_BIT cycles → DATA.
  - DATA: tx=sh[0] for TICKS_PER_BIT cycles per bit.
    - At each bit end: sh shifts right, bit_count increments.
    - After bit 7 completes → PARITY if the feature is enabled, else → STOP.
  - STOP: tx=1 for STOP_BITS*TICKS_PER_BIT cycles → IDLE.
- Tick counter:
  - 16-bit; counts 0..TICKS_PER_BIT-1.
  - Wraps to 0 at the end of each bit.
  - Held at 0 in IDLE.
- Bit counter: 3 bits plus done flag; cleared on entry to DATA.
- Latency: acceptance edge to tx falling = 1 cycle.
- Frame length: (10 + STOP_BITS - 1) × TICKS_PER_BIT cycles, plus TICKS_PER_BIT when parity is enabled.
- Back-to-back: after STOP, IDLE lasts ≥1 cycle with ready=1.
  - Minimum accept-to-accept period = frame length + 1 cycle.
  - The extra idle cycle keeps tx=1, so stop-bit length is never shortened.
- busy=1 from the cycle after acceptance until the cycle IDLE is re-entered.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds parameter PARITY_ODD (default 0).
  - Parity bit computed at acceptance: ^data ^ PARITY_ODD.
  - Parity is sent in the PARITY state for TICKS_PER_BIT cycles, between data bit 7 and the stop bit(s).
- Undefined:
  - The PARITY state encoding is unused.
  - DATA goes directly to STOP.
  - No parity register exists; frame is 8N STOP_BITS.

Decomposition:
- Package uart_pkg:
  - 3-bit state encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=5. The receiver uses the same encodings.
  - NUM_DATA_BITS=8.
  - Function ticks_per_bit(clk_hz, baud).
- One natural sub-module, uart_baud_tick:
  - Parameterised TICKS_PER_BIT counter.
  - Inputs: clear and enable. Output: 1-cycle `bit_end` pulse.
  - Reusable by the receiver.

Test Plan:
- CLK_FREQUENCY=8_000_000, UART_FREQUENCY=1_000_000 (T=8); send 0xA5 → tx = 0,1,0,1,0,0,1,0,1,1, each bit exactly 8 cycles. Tx falls 1 cycle after acceptance; ready returns after 80 cycles.
- Hold valid=1 with 0x00 then 0xFF queued → two frames; accept edges exactly 81 cycles apart; tx never low during stop or gap.
- valid pulsed with 0x3C while busy → ignored; the in-flight frame is unchanged and no second frame is sent.
- rst_n low at cycle 30 of a 0x00 frame → tx=1 immediately and ready=0. After release: ready=1 next cycle; new byte 0x81 is sent correctly.
- STOP_BITS=2, T=8, 0x55 → stop high for 16 cycles; frame is 88 cycles.
- UART_TX_PARITY_EN defined, PARITY_ODD=0: 0x07 → parity bit 1. PARITY_ODD=1 → parity bit 0. Frame is 88 cycles with STOP_BITS=1.
